// File: rtl/mips_pkg.sv
// Shared definitions for the 8-bit multicycle MIPS core and its boot loader.
package mips_pkg;

  // Memory geometry of the core: 8-bit address, 8-bit data.
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  // Boot loader states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,  // waiting for the length byte
    LOAD  = 3'd1,  // receiving payload bytes and writing them to memory
    CHECK = 3'd2,  // waiting for the checksum byte
    RUN   = 3'd3,  // CPU released and owns the memory port
    ERR   = 3'd4   // checksum mismatch, CPU held in reset
  } loader_state_e;

endpackage

// File: rtl/mem_port_mux.sv
// Selects which agent drives the shared memory write/address port:
// the loader write register (sel=0) or the CPU (sel=1).
module mem_port_mux
  import mips_pkg::*;
(
  input  logic              sel,
  input  logic              ld_memwrite,
  input  logic [ADDR_W-1:0] ld_adr,
  input  logic [DATA_W-1:0] ld_writedata,
  input  logic              cpu_memwrite,
  input  logic [ADDR_W-1:0] cpu_adr,
  input  logic [DATA_W-1:0] cpu_writedata,
  output logic              mem_memwrite,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_writedata
);

  // Purely combinational select; CPU strobes are dropped while the loader owns the port.
  always_comb begin
    if (sel) begin
      mem_memwrite  = cpu_memwrite;
      mem_adr       = cpu_adr;
      mem_writedata = cpu_writedata;
    end else begin
      mem_memwrite  = ld_memwrite;
      mem_adr       = ld_adr;
      mem_writedata = ld_writedata;
    end
  end

endmodule

// File: rtl/mips_boot_loader.sv
// Program loader for the 8-bit multicycle MIPS core. Receives a stream of
// <length> <payload...> <checksum> bytes, writes the payload into memory
// starting at LOAD_BASE, then releases the CPU on a good checksum.
// A length byte of 0 means 256 payload bytes.
module mips_boot_loader
  import mips_pkg::*;
#(
  parameter logic [ADDR_W-1:0] LOAD_BASE = 8'h00
) (
  input  logic              clk,
  input  logic              reset,
  // byte stream
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              reload,
  // CPU side
  output logic              cpu_reset,
  input  logic              cpu_memwrite,
  input  logic [ADDR_W-1:0] cpu_adr,
  input  logic [DATA_W-1:0] cpu_writedata,
  output logic [DATA_W-1:0] cpu_memdata,
  // memory side
  output logic              mem_memwrite,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_memdata,
  // status
  output logic              running,
  output logic              load_err
);

  loader_state_e     state_reg;
  logic [ADDR_W-1:0] len_m1_reg;   // payload length minus one (length 0 -> 255)
  logic [ADDR_W-1:0] idx_reg;      // index of the next payload byte
  logic [DATA_W-1:0] sum_reg;      // running checksum, mod 256
  logic              wr_en_reg;    // one-cycle loader write strobe
  logic [ADDR_W-1:0] wr_adr_reg;
  logic [DATA_W-1:0] wr_data_reg;
  logic              cpu_reset_reg;
  logic              xfer;

  // Input handshake: bytes are only taken while the stream is being parsed.
  always_comb begin
    in_ready = (state_reg == IDLE) || (state_reg == LOAD) || (state_reg == CHECK);
    xfer     = in_valid && in_ready;
  end

  // Sequencing of the load and ownership of CPU reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      cpu_reset_reg <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (xfer) state_reg <= LOAD;
        end
        LOAD: begin
          if (xfer && (idx_reg == len_m1_reg)) state_reg <= CHECK;
        end
        CHECK: begin
          if (xfer) begin
            if (in_data == sum_reg) begin
              state_reg     <= RUN;
              cpu_reset_reg <= 1'b0;
            end else begin
              state_reg     <= ERR;
            end
          end
        end
        RUN, ERR: begin
          if (reload) begin
            state_reg     <= IDLE;
            cpu_reset_reg <= 1'b1;
          end
        end
        default: begin
          state_reg     <= IDLE;
          cpu_reset_reg <= 1'b1;
        end
      endcase
    end
  end

  // Length/index/checksum bookkeeping and the registered loader write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      len_m1_reg  <= '0;
      idx_reg     <= '0;
      sum_reg     <= '0;
      wr_en_reg   <= 1'b0;
      wr_adr_reg  <= LOAD_BASE;
      wr_data_reg <= '0;
    end else begin
      // The strobe is a single-cycle pulse per accepted payload byte.
      wr_en_reg <= 1'b0;
      if (xfer && (state_reg == IDLE)) begin
        len_m1_reg <= in_data - 8'd1;
        idx_reg    <= '0;
        sum_reg    <= '0;
      end
      if (xfer && (state_reg == LOAD)) begin
        wr_en_reg   <= 1'b1;
        wr_adr_reg  <= LOAD_BASE + idx_reg;  // 8-bit wrap is intended
        wr_data_reg <= in_data;
        sum_reg     <= sum_reg + in_data;
        idx_reg     <= idx_reg + 8'd1;
      end
    end
  end

  // Status outputs decode directly from the state register.
  always_comb begin
    running   = (state_reg == RUN);
    load_err  = (state_reg == ERR);
    cpu_reset = cpu_reset_reg;
  end

  assign cpu_memdata = mem_memdata;

  mem_port_mux u_mux (
    .sel           (running),
    .ld_memwrite   (wr_en_reg),
    .ld_adr        (wr_adr_reg),
    .ld_writedata  (wr_data_reg),
    .cpu_memwrite  (cpu_memwrite),
    .cpu_adr       (cpu_adr),
    .cpu_writedata (cpu_writedata),
    .mem_memwrite  (mem_memwrite),
    .mem_adr       (mem_adr),
    .mem_writedata (mem_writedata)
  );

endmodule

// File: doc/mips_boot_loader.md
# mips_boot_loader

Program loader and memory-port owner for the 8-bit multicycle MIPS core. Holds the CPU in reset while it accepts a length-prefixed, checksummed byte stream on a valid/ready input and writes the bytes into the shared 8-bit memory. On a good checksum it hands the memory port to the CPU and releases CPU reset. It sits between the CPU top level and the memory, muxing the single address/write port.

## Interface
- LOAD_BASE, 8'h00, first memory address written; byte i goes to (LOAD_BASE + i) mod 256
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; one clock, no other clock domains
- in_valid  in  1  input byte valid
- in_data  in  8  input byte
- in_ready  out  1  loader accepts byte; transfer = in_valid & in_ready
- reload  in  1  in RUN or ERR: return to IDLE and re-assert CPU reset
- cpu_reset  out  1  reset to CPU controller, registered
- cpu_memwrite  in  1  CPU memory write strobe
- cpu_adr  in  8  CPU address
- cpu_writedata  in  8  CPU write data
- cpu_memdata  out  8  read data to CPU, equals mem_memdata combinationally
- mem_memwrite  out  1  memory write strobe
- mem_adr  out  8  memory address
- mem_writedata  out  8  memory write data
- mem_memdata  in  8  memory read data
- running  out  1  state == RUN
- load_err  out  1  state == ERR

## Operation
- States: IDLE, LOAD, CHECK, RUN, ERR. Reset enters IDLE.
- IDLE: in_ready=1. A transfer latches N=in_data, where 0 means 256. Clears index and sum. Next state is LOAD.
- LOAD: in_ready=1. Each transfer registers a write to address LOAD_BASE+index with data in_data, adds in_data to sum mod 256, and increments index. The transfer with index==N-1 moves to CHECK.
- CHECK: in_ready=1. A transfer compares in_data with sum. Match goes to RUN; mismatch goes to ERR. No memory write occurs.
- RUN: in_ready=0. Memory port passes through: mem_* = cpu_*.
- ERR: in_ready=0. cpu_reset stays 1 and the memory port stays on the loader with mem_memwrite=0.
- reload in RUN or ERR goes to IDLE. reload in IDLE, LOAD or CHECK is ignored.
- Outside RUN, mem_adr/mem_writedata come from the loader write register and mem_memwrite comes from the loader strobe only. CPU strobes are dropped.
- Address arithmetic is 8-bit and wraps, e.g. LOAD_BASE=8'hF0 with N=32 writes F0..FF then 00..0F.
- Memory contents are never cleared by the loader.

## Timing
- Reset values: cpu_reset=1, mem_memwrite=0, mem_adr=LOAD_BASE, mem_writedata=0, in_ready=1, running=0, load_err=0.
- Write latency: a transfer at edge k produces mem_memwrite=1 for exactly one cycle, k to k+1, with the matching adr and data. Back-to-back transfers give back-to-back writes. The last data write completes during the first CHECK cycle.
- On a CHECK match at edge k, state becomes RUN and cpu_reset becomes 0 on the same edge. The CPU sees reset low from cycle k onward.
- reload at edge k sets state to IDLE and cpu_reset to 1 on the same edge. The mux returns to the loader in the same cycle.
- in_valid gaps stall the loader with no timeout. in_data is ignored while in_ready=0.
- reset mid-LOAD: IDLE next cycle, cpu_reset=1. Writes already done remain. No write is issued in the reset cycle.

## Structure
- Shared package mips_pkg holds:
  - the loader state enum (IDLE, LOAD, CHECK, RUN, ERR);
  - constants ADDR_W=8 and DATA_W=8, matching the core's memory width.
- One natural sub-module, mem_port_mux: combinational select between loader and CPU drivers, with sel=running.
- FSM, counters and checksum live in mips_boot_loader.

## Test plan
- Good load: stream 03,20,01,05,26. Writes 00←20, 01←01, 02←05 on consecutive cycles. Then running=1 and cpu_reset=0 the cycle after the 26 transfer. CPU writes then pass to mem_*.
- Bad checksum: stream 03,20,01,05,27. Same three writes, then load_err=1, cpu_reset stays 1, in_ready=0. CPU memwrite=1 never reaches mem_memwrite.
- Wrap and max length: LOAD_BASE=8'hF0, length 00, 256 bytes of value i, checksum 80. Addresses F0..FF,00..EF, running=1.
- Backpressure: random in_valid gaps during the good load. Identical writes and final state, and no write is issued in idle cycles.
- Reload: reload=1 in RUN. Next cycle cpu_reset=1, running=0, in_ready=1. A second load to new data succeeds.
- Reset mid-load: reset after 2 of 3 data bytes. Returns to IDLE with cpu_reset=1. A fresh stream 01,AA,AA loads 00←AA and runs.
